// File: rtl/dram_cmd_decoder.sv
// DDR4 command/address pin receiver: decodes each sampled command, tracks per-bank
// open state and tRCD/tRP/tRFC spacing, and flags protocol violations one cycle later.
module dram_cmd_decoder #(
    parameter int BANK_GROUP_BITS = 2,
    parameter int BANK_BITS       = 2,
    parameter int ADDR_BITS       = 14,
    parameter int COLUMN_BITS     = 10,
    parameter int T_RCD           = 16,
    parameter int T_RP            = 16,
    parameter int T_RFC           = 350
) (
    input  logic                                           CLK,
    input  logic                                           RST,
    input  logic                                           RESET_n,
    input  logic                                           CKE,
    input  logic                                           CS_n,
    input  logic                                           ACT_n,
    input  logic                                           RAS_n_A16,
    input  logic                                           CAS_n_A15,
    input  logic                                           WE_n_A14,
    input  logic [BANK_GROUP_BITS-1:0]                     BG,
    input  logic [BANK_BITS-1:0]                           BA,
    input  logic [ADDR_BITS-1:0]                           ADDR,
    output logic                                           cmd_valid,
    output logic [3:0]                                     cmd,
    output logic [BANK_GROUP_BITS-1:0]                     cmd_bg,
    output logic [BANK_BITS-1:0]                           cmd_ba,
    output logic [ADDR_BITS+2:0]                           cmd_row,
    output logic [COLUMN_BITS-1:0]                         cmd_col,
    output logic                                           cmd_ap,
    output logic [(1<<(BANK_GROUP_BITS+BANK_BITS))-1:0]    bank_open,
    output logic                                           err_valid,
    output logic [2:0]                                     err_code
);
    localparam int NUM_BANKS = 1 << (BANK_GROUP_BITS + BANK_BITS);
    localparam int IDX_W     = BANK_GROUP_BITS + BANK_BITS;
    localparam int ROW_BITS  = ADDR_BITS + 3;
    localparam int BT_MAX    = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int BT_W      = (BT_MAX > 1) ? $clog2(BT_MAX) : 1;
    localparam int RF_W      = (T_RFC > 1) ? $clog2(T_RFC) : 1;
    localparam logic [BT_W-1:0] RCD_LOAD = BT_W'(T_RCD - 1);
    localparam logic [BT_W-1:0] RP_LOAD  = BT_W'(T_RP - 1);
    localparam logic [RF_W-1:0] RFC_LOAD = RF_W'(T_RFC - 1);

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0, CMD_ACT = 4'd1, CMD_RD  = 4'd2, CMD_WR  = 4'd3, CMD_PRE = 4'd4,
        CMD_PREA = 4'd5, CMD_REF = 4'd6, CMD_MRS = 4'd7, CMD_ZQC = 4'd8, CMD_RFU = 4'd9
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0, ERR_ACT_OPEN = 3'd1, ERR_CLOSED = 3'd2, ERR_TRCD = 3'd3,
        ERR_TRP = 3'd4, ERR_TRFC = 3'd5, ERR_REF_OPEN = 3'd6, ERR_RFU = 3'd7
    } err_e;

    logic [IDX_W-1:0]     bank_idx;
    cmd_e                 dec_cmd;
    err_e                 err_d,       err_q;
    logic [NUM_BANKS-1:0] open_d,      open_q;
    logic [NUM_BANKS-1:0] rp_tag_d,    rp_tag_q;   // 1: timer counts tRP, 0: tRCD
    logic [BT_W-1:0]      timer_d [NUM_BANKS];
    logic [BT_W-1:0]      timer_q [NUM_BANKS];
    logic [RF_W-1:0]      ref_timer_d, ref_timer_q;
    cmd_e                 cmd_q;
    logic [IDX_W-1:0]     tgt_q;
    logic [ROW_BITS-1:0]  row_d,       row_q;
    logic [COLUMN_BITS-1:0] col_d,     col_q;
    logic                 ap_d,        ap_q;
    logic                 is_rdwr;

    assign bank_idx = {BG, BA};
    assign is_rdwr  = (dec_cmd == CMD_RD) || (dec_cmd == CMD_WR);

    always_comb begin
        dec_cmd = CMD_NOP;
        if (RESET_n && CKE && !CS_n) begin
            if (!ACT_n) begin
                dec_cmd = CMD_ACT;
            end else begin
                case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
                    3'b000:  dec_cmd = CMD_MRS;
                    3'b001:  dec_cmd = CMD_REF;
                    3'b010:  dec_cmd = ADDR[10] ? CMD_PREA : CMD_PRE;
                    3'b011:  dec_cmd = CMD_RFU;
                    3'b100:  dec_cmd = CMD_WR;
                    3'b101:  dec_cmd = CMD_RD;
                    3'b110:  dec_cmd = CMD_ZQC;
                    default: dec_cmd = CMD_NOP;
                endcase
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        err_d       = ERR_NONE;
        open_d      = open_q;
        rp_tag_d    = rp_tag_q;
        ref_timer_d = (ref_timer_q == '0) ? '0 : ref_timer_q - 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            timer_d[i] = (timer_q[i] == '0) ? '0 : timer_q[i] - 1'b1;
        end

        case (dec_cmd)
            CMD_ACT: begin
                if (open_q[bank_idx]) begin
                    err_d = ERR_ACT_OPEN;
                end else begin
                    if (rp_tag_q[bank_idx] && timer_q[bank_idx] != '0) err_d = ERR_TRP;
                    else if (ref_timer_q != '0)                       err_d = ERR_TRFC;
                    open_d[bank_idx]   = 1'b1;
                    rp_tag_d[bank_idx] = 1'b0;
                    timer_d[bank_idx]  = RCD_LOAD;
                end
            end
            CMD_RD, CMD_WR: begin
                if (!open_q[bank_idx]) begin
                    err_d = ERR_CLOSED;
                end else begin
                    if (!rp_tag_q[bank_idx] && timer_q[bank_idx] != '0) err_d = ERR_TRCD;
                    if (ADDR[10]) begin
                        open_d[bank_idx]   = 1'b0;
                        rp_tag_d[bank_idx] = 1'b1;
                        timer_d[bank_idx]  = RP_LOAD;
                    end
                end
            end
            CMD_PRE: begin
                if (open_q[bank_idx]) begin
                    open_d[bank_idx]   = 1'b0;
                    rp_tag_d[bank_idx] = 1'b1;
                    timer_d[bank_idx]  = RP_LOAD;
                end
            end
            CMD_PREA: begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (open_q[i]) begin
                        open_d[i]   = 1'b0;
                        rp_tag_d[i] = 1'b1;
                        timer_d[i]  = RP_LOAD;
                    end
                end
            end
            CMD_REF: begin
                if (ref_timer_q != '0) err_d = ERR_TRFC;
                else if (|open_q)      err_d = ERR_REF_OPEN;
                ref_timer_d = RFC_LOAD;
            end
            CMD_RFU: err_d = ERR_RFU;
            default: ;
        endcase

        if (!RESET_n) begin
            open_d      = '0;
            rp_tag_d    = '0;
            ref_timer_d = '0;
            for (int i = 0; i < NUM_BANKS; i++) timer_d[i] = '0;
        end
    end

    assign row_d = (dec_cmd == CMD_ACT) ? {RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR} : '0;
    assign col_d = is_rdwr ? ADDR[COLUMN_BITS-1:0] : '0;
    assign ap_d  = is_rdwr && ADDR[10];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            open_q      <= '0;
            rp_tag_q    <= '0;
            ref_timer_q <= '0;
            // NOTE: the timer array is reset too; every bank must come up with its timer expired.
            for (int i = 0; i < NUM_BANKS; i++) timer_q[i] <= '0;
            cmd_q       <= CMD_NOP;
            err_q       <= ERR_NONE;
            tgt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ap_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            open_q      <= open_d;
            rp_tag_q    <= rp_tag_d;
            ref_timer_q <= ref_timer_d;
            for (int i = 0; i < NUM_BANKS; i++) timer_q[i] <= timer_d[i];
            cmd_q       <= dec_cmd;
            err_q       <= err_d;
            tgt_q       <= (dec_cmd != CMD_NOP) ? bank_idx : '0;
            row_q       <= row_d;
            col_q       <= col_d;
            ap_q        <= ap_d;
        end
    end

    assign cmd_valid = (cmd_q != CMD_NOP);
    assign cmd       = cmd_q;
    assign cmd_bg    = tgt_q[IDX_W-1:BANK_BITS];
    assign cmd_ba    = tgt_q[BANK_BITS-1:0];
    assign cmd_row   = row_q;
    assign cmd_col   = col_q;
    assign cmd_ap    = ap_q;
    assign bank_open = open_q;
    assign err_valid = (err_q != ERR_NONE);
    assign err_code  = err_q;
endmodule

// File: tb/tb_dram_cmd_decoder.sv
// Directed bench for dram_cmd_decoder: a vector table of single commands with
// hand-computed expectations, plus an asynchronous-reset sequence.
module tb_dram_cmd_decoder;
    localparam int BGB = 2;
    localparam int BAB = 2;
    localparam int AB  = 14;
    localparam int CB  = 10;

    // {ACT_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] P_NOP  = 4'b1111;
    localparam logic [3:0] P_ACT  = 4'b0000;
    localparam logic [3:0] P_RD   = 4'b1101;
    localparam logic [3:0] P_WR   = 4'b1100;
    localparam logic [3:0] P_PRE  = 4'b1010;
    localparam logic [3:0] P_REF  = 4'b1001;
    localparam logic [3:0] P_MRS  = 4'b1000;
    localparam logic [3:0] P_ZQC  = 4'b1110;
    localparam logic [3:0] P_RFU  = 4'b1011;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RESET_n, CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic [BGB-1:0] BG;
    logic [BAB-1:0] BA;
    logic [AB-1:0]  ADDR;
    logic           cmd_valid, cmd_ap, err_valid;
    logic [3:0]     cmd;
    logic [BGB-1:0] cmd_bg;
    logic [BAB-1:0] cmd_ba;
    logic [AB+2:0]  cmd_row;
    logic [CB-1:0]  cmd_col;
    logic [15:0]    bank_open;
    logic [2:0]     err_code;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dram_cmd_decoder #(
        .BANK_GROUP_BITS(BGB), .BANK_BITS(BAB), .ADDR_BITS(AB), .COLUMN_BITS(CB),
        .T_RCD(16), .T_RP(16), .T_RFC(350)
    ) dut (
        .CLK(CLK), .RST(RST), .RESET_n(RESET_n), .CKE(CKE), .CS_n(CS_n), .ACT_n(ACT_n),
        .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
        .BG(BG), .BA(BA), .ADDR(ADDR),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap), .bank_open(bank_open),
        .err_valid(err_valid), .err_code(err_code)
    );

    typedef struct {
        string       name;
        int          gap;       // cycles since the previous command was sampled
        logic        rst_n_pin;
        logic        cke;
        logic        cs_n;
        logic [3:0]  pins;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [13:0] addr;
        logic [3:0]  exp_cmd;
        logic [2:0]  exp_err;
        logic [15:0] exp_open;
        logic [16:0] exp_row;
        logic [9:0]  exp_col;
        logic        exp_ap;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic ck, input logic csn, input logic [3:0] p,
                         input logic [1:0] g, input logic [1:0] a, input logic [13:0] ad);
        RESET_n = rn;
        CKE     = ck;
        CS_n    = csn;
        {ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = p;
        BG      = g;
        BA      = a;
        ADDR    = ad;
    endtask

    function automatic vec_t mk(input string name, input int gap, input logic [3:0] pins,
                                input logic [1:0] bg, input logic [1:0] ba, input logic [13:0] addr,
                                input logic [3:0] exp_cmd, input logic [2:0] exp_err,
                                input logic [15:0] exp_open);
        vec_t v;
        v.name = name;  v.gap = gap;  v.rst_n_pin = 1'b1;  v.cke = 1'b1;  v.cs_n = 1'b0;
        v.pins = pins;  v.bg = bg;    v.ba = ba;           v.addr = addr;
        v.exp_cmd = exp_cmd;  v.exp_err = exp_err;  v.exp_open = exp_open;
        v.exp_row = (exp_cmd == 4'd1) ? {pins[2:0], addr} : 17'h0;
        v.exp_col = (exp_cmd == 4'd2 || exp_cmd == 4'd3) ? addr[9:0] : 10'h0;
        v.exp_ap  = (exp_cmd == 4'd2 || exp_cmd == 4'd3) && addr[10];
        return v;
    endfunction

    // Starts just after the negedge following the previous sampling edge.
    task automatic apply(input vec_t v);
        logic is_cmd;
        drive(1'b1, 1'b1, 1'b0, P_NOP, 2'd0, 2'd0, 14'h0);
        repeat (v.gap - 1) @(negedge CLK);
        drive(v.rst_n_pin, v.cke, v.cs_n, v.pins, v.bg, v.ba, v.addr);
        @(negedge CLK);
        is_cmd = (v.exp_cmd != 4'd0);
        check({v.name, ".cmd_valid"}, 32'(cmd_valid), 32'(is_cmd));
        check({v.name, ".cmd"},       32'(cmd),       32'(v.exp_cmd));
        check({v.name, ".cmd_bg"},    32'(cmd_bg),    is_cmd ? 32'(v.bg) : 32'd0);
        check({v.name, ".cmd_ba"},    32'(cmd_ba),    is_cmd ? 32'(v.ba) : 32'd0);
        check({v.name, ".cmd_row"},   32'(cmd_row),   32'(v.exp_row));
        check({v.name, ".cmd_col"},   32'(cmd_col),   32'(v.exp_col));
        check({v.name, ".cmd_ap"},    32'(cmd_ap),    32'(v.exp_ap));
        check({v.name, ".err_valid"}, 32'(err_valid), 32'(v.exp_err != 3'd0));
        check({v.name, ".err_code"},  32'(err_code),  32'(v.exp_err));
        check({v.name, ".bank_open"}, 32'(bank_open), 32'(v.exp_open));
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;

        //                name           gap  pins    bg    ba    addr     cmd err open
        v = mk("act_b6_row",     1, 4'b0101, 2'd1, 2'd2, 14'h0123, 4'd1, 3'd0, 16'h0040);
        v.exp_row = 17'h14123;
        vecs.push_back(v);
        vecs.push_back(mk("act_b0",       1, P_ACT, 2'd0, 2'd0, 14'h0000, 4'd1, 3'd0, 16'h0041));
        vecs.push_back(mk("rd_b0_trcd15",15, P_RD,  2'd0, 2'd0, 14'h0155, 4'd2, 3'd3, 16'h0041));
        vecs.push_back(mk("act_b1",       1, P_ACT, 2'd0, 2'd1, 14'h0abc, 4'd1, 3'd0, 16'h0043));
        vecs.push_back(mk("rd_b1_trcd16",16, P_RD,  2'd0, 2'd1, 14'h02ab, 4'd2, 3'd0, 16'h0043));
        vecs.push_back(mk("nop",          1, P_NOP, 2'd0, 2'd0, 14'h0000, 4'd0, 3'd0, 16'h0043));
        vecs.push_back(mk("rd_b2_closed", 1, P_RD,  2'd0, 2'd2, 14'h0001, 4'd2, 3'd2, 16'h0043));
        vecs.push_back(mk("act_b0_open",  1, P_ACT, 2'd0, 2'd0, 14'h0000, 4'd1, 3'd1, 16'h0043));
        vecs.push_back(mk("act_b3",       1, P_ACT, 2'd0, 2'd3, 14'h0000, 4'd1, 3'd0, 16'h004B));
        vecs.push_back(mk("wr_b3_ap",    16, P_WR,  2'd0, 2'd3, 14'h0405, 4'd3, 3'd0, 16'h0043));
        vecs.push_back(mk("act_b3_trp10",10, P_ACT, 2'd0, 2'd3, 14'h0000, 4'd1, 3'd4, 16'h004B));
        vecs.push_back(mk("pre_b3",      16, P_PRE, 2'd0, 2'd3, 14'h0000, 4'd4, 3'd0, 16'h0043));
        vecs.push_back(mk("act_b3_trp16",16, P_ACT, 2'd0, 2'd3, 14'h0000, 4'd1, 3'd0, 16'h004B));
        vecs.push_back(mk("pre_b2_closed",1, P_PRE, 2'd0, 2'd2, 14'h0000, 4'd4, 3'd0, 16'h004B));
        vecs.push_back(mk("act_b5",       1, P_ACT, 2'd1, 2'd1, 14'h0000, 4'd1, 3'd0, 16'h006B));
        vecs.push_back(mk("prea",         1, P_PRE, 2'd0, 2'd0, 14'h0400, 4'd5, 3'd0, 16'h0000));
        vecs.push_back(mk("ref_clean",    1, P_REF, 2'd0, 2'd0, 14'h0000, 4'd6, 3'd0, 16'h0000));
        vecs.push_back(mk("act_b2_rfc349",349,P_ACT,2'd0, 2'd2, 14'h0000, 4'd1, 3'd5, 16'h0004));
        vecs.push_back(mk("act_b4_rfc350",1, P_ACT, 2'd1, 2'd0, 14'h0000, 4'd1, 3'd0, 16'h0014));
        vecs.push_back(mk("ref_bank_open",1, P_REF, 2'd0, 2'd0, 14'h0000, 4'd6, 3'd6, 16'h0014));
        vecs.push_back(mk("ref_prio_rfc", 1, P_REF, 2'd0, 2'd0, 14'h0000, 4'd6, 3'd5, 16'h0014));
        vecs.push_back(mk("mrs",          1, P_MRS, 2'd0, 2'd0, 14'h0000, 4'd7, 3'd0, 16'h0014));
        vecs.push_back(mk("zqc",          1, P_ZQC, 2'd0, 2'd0, 14'h0000, 4'd8, 3'd0, 16'h0014));
        v = mk("cke_low_act",    1, P_ACT, 2'd1, 2'd3, 14'h0000, 4'd0, 3'd0, 16'h0014);
        v.cke = 1'b0;
        vecs.push_back(v);
        v = mk("deselect_rd",    1, P_RD,  2'd1, 2'd0, 14'h0000, 4'd0, 3'd0, 16'h0014);
        v.cs_n = 1'b1;
        vecs.push_back(v);
        vecs.push_back(mk("rfu",          1, P_RFU, 2'd0, 2'd0, 14'h0000, 4'd9, 3'd7, 16'h0014));
        v = mk("reset_n_low",    1, P_ACT, 2'd1, 2'd3, 14'h0000, 4'd0, 3'd0, 16'h0000);
        v.rst_n_pin = 1'b0;
        vecs.push_back(v);
        vecs.push_back(mk("act_b7_after_rn",1,P_ACT,2'd1, 2'd3, 14'h0000, 4'd1, 3'd0, 16'h0080));

        RST = 1'b1;
        drive(1'b1, 1'b1, 1'b0, P_NOP, 2'd0, 2'd0, 14'h0);
        repeat (2) @(negedge CLK);
        check("reset.cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset.cmd",       32'(cmd),       32'd0);
        check("reset.err_valid", 32'(err_valid), 32'd0);
        check("reset.err_code",  32'(err_code),  32'd0);
        check("reset.bank_open", 32'(bank_open), 32'd0);
        check("reset.cmd_row",   32'(cmd_row),   32'd0);
        RST = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset with banks open and tRCD running, then an immediate RD.
        apply(mk("seq_act_b0", 1, P_ACT, 2'd0, 2'd0, 14'h0000, 4'd1, 3'd0, 16'h0081));
        drive(1'b1, 1'b1, 1'b0, P_NOP, 2'd0, 2'd0, 14'h0);
        #2 RST = 1'b1;
        #1;
        check("async_rst.bank_open", 32'(bank_open), 32'd0);
        check("async_rst.cmd_valid", 32'(cmd_valid), 32'd0);
        check("async_rst.cmd",       32'(cmd),       32'd0);
        #1 RST = 1'b0;
        apply(mk("seq_rd_after_rst", 1, P_RD, 2'd0, 2'd0, 14'h0010, 4'd2, 3'd2, 16'h0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
